radix4div: RTL and testbench

Sequential unsigned radix-4 divider: the inverse of the radix-4 Booth multipliers in the unsigned datapath. It takes a 2N-bit dividend (a product-width value) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder. It retires two quotient bits per cycle using a restoring digit-select against d, 2d and 3d, and sits behind a valid/ready handshake on both the operand side and the result side.

---
 rtl/radix4div_pkg.sv | 24 ++
 rtl/radix4div_if.sv | 32 +++
 rtl/radix4div_digit_sel.sv | 44 ++++
 rtl/radix4div.sv | 121 ++++++++++++
 tb/tb_radix4div.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/radix4div_pkg.sv
// ----------------------------------------------------------------------------
// radix4div_pkg : shared types and helpers for the radix-4 restoring divider
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package radix4div_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two quotient bits retire per iteration.
  function automatic int iters(input int n);
    return n / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/radix4div_if.sv
// ----------------------------------------------------------------------------
// radix4div_if : operand/result handshake bundle for the radix-4 divider
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface radix4div_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     q;
  logic [N-1:0]     r;
  logic             err_dbz;
  logic             err_ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, q, r, err_dbz, err_ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, q, r, err_dbz, err_ovf
  );
endinterface

`default_nettype wire

// File: rtl/radix4div_digit_sel.sv
// ----------------------------------------------------------------------------
// radix4div_digit_sel : picks the largest k in {3,2,1,0} with k*d <= R'
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module radix4div_digit_sel
  import radix4div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N+1:0]       rp,
  input  logic [N+1:0]       d1,
  input  logic [N+1:0]       d2,
  input  logic [N+1:0]       d3,
  output logic [DIGIT_W-1:0] k,
  output logic [N-1:0]       rem
);

  // The chosen difference is always below d, so the low N bits are exact.
  logic [N-1:0] sub1, sub2, sub3;

  assign sub1 = rp[N-1:0] - d1[N-1:0];
  assign sub2 = rp[N-1:0] - d2[N-1:0];
  assign sub3 = rp[N-1:0] - d3[N-1:0];

  always_comb begin
    k   = '0;
    rem = rp[N-1:0];
    if (rp >= d3) begin
      k   = 2'd3;
      rem = sub3;
    end else if (rp >= d2) begin
      k   = 2'd2;
      rem = sub2;
    end else if (rp >= d1) begin
      k   = 2'd1;
      rem = sub1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/radix4div.sv
// ----------------------------------------------------------------------------
// radix4div : sequential unsigned 2N/N radix-4 restoring divider
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module radix4div
  import radix4div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  radix4div_if.slave  bus
);

  localparam int K  = iters(N);
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_t               state, state_nxt;
  logic [N+1:0]         d1, d2, d3;
  logic [N-1:0]         rem, qsh;
  logic [CW-1:0]        cnt;
  logic [N-1:0]         q_reg, r_reg;
  logic                 dbz, ovf;
  logic [N-1:0]         hi, lo;
  logic                 div_zero, div_ovf;
  logic [N+1:0]         rp;
  logic [DIGIT_W-1:0]   k;
  logic [N-1:0]         rem_nxt;
  logic [N-1:0]         qsh_nxt;

  assign hi       = bus.dividend[2*N-1:N];
  assign lo       = bus.dividend[N-1:0];
  assign div_zero = (bus.divisor == '0);
  assign div_ovf  = (hi >= bus.divisor);
  assign rp       = {rem, qsh[N-1:N-2]};
  assign qsh_nxt  = {qsh[N-3:0], k};

  radix4div_digit_sel #(.N(N)) u_digit_sel (
    .rp  (rp),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .k   (k),
    .rem (rem_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (div_zero || div_ovf) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      rem   <= '0;
      qsh   <= '0;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            d1  <= {2'b00, bus.divisor};
            d2  <= {1'b0, bus.divisor, 1'b0};
            d3  <= {2'b00, bus.divisor} + {1'b0, bus.divisor, 1'b0};
            rem <= hi;
            qsh <= lo;
            cnt <= CW'(K - 1);
            // Exceptions skip iteration and report a saturated quotient.
            if (div_zero || div_ovf) begin
              dbz   <= div_zero;
              ovf   <= ~div_zero;
              q_reg <= '1;
              r_reg <= lo;
            end else begin
              dbz <= 1'b0;
              ovf <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          qsh <= qsh_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            q_reg <= qsh_nxt;
            r_reg <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_reg;
  assign bus.r         = r_reg;
  assign bus.err_dbz   = dbz;
  assign bus.err_ovf   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_radix4div.sv
// ----------------------------------------------------------------------------
// tb_radix4div : directed self-checking bench for radix4div (N=8)
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_radix4div;
  import radix4div_pkg::*;

  localparam int N = 8;
  localparam int K = N / 2;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  radix4div_if #(.N(N)) bus ();

  radix4div #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, cyc);
    end
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b vld=%0b q=%0d r=%0d dbz=%0b ovf=%0b, required 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(16'd1000, 8'd7);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy: in_ready=%0b, required 0", bus.in_ready);
    end
    wait_valid(cyc);
    vectors++;
    if (cyc != K) begin
      errors++; $display("FAIL basic_latency: %0d cycles, required %0d", cyc, K);
    end
    vectors++;
    if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {8'd142, 8'd6, 2'b00}) begin
      errors++; $display("FAIL basic_result: q=%0d r=%0d dbz=%0b ovf=%0b, required 142 6 0 0",
                         bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    release_result();
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_release: rdy=%0b vld=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_max_quotient;
    int cyc;
    start_op(16'hFEFF, 8'hFF);
    wait_valid(cyc);
    vectors++;
    if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {8'd255, 8'd254, 2'b00}) begin
      errors++; $display("FAIL max_quotient: q=%0d r=%0d dbz=%0b ovf=%0b, required 255 254 0 0",
                         bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    release_result();
  endtask

  task automatic test_overflow;
    int cyc;
    start_op(16'h0700, 8'd7);
    wait_valid(cyc);
    vectors++;
    if (cyc != 0) begin
      errors++; $display("FAIL ovf_latency: %0d cycles, required 0", cyc);
    end
    vectors++;
    if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {8'hFF, 8'h00, 2'b01}) begin
      errors++; $display("FAIL ovf_result: q=%h r=%h dbz=%0b ovf=%0b, required ff 00 0 1",
                         bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    release_result();
  endtask

  task automatic test_div_by_zero;
    int cyc;
    start_op(16'h0010, 8'd0);
    wait_valid(cyc);
    vectors++;
    if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {8'hFF, 8'h10, 2'b10}) begin
      errors++; $display("FAIL dbz_result: q=%h r=%h dbz=%0b ovf=%0b, required ff 10 1 0",
                         bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    // New operands held during DONE must not be taken.
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.q, bus.r, bus.err_dbz} !== {2'b10, 8'hFF, 8'h10, 1'b1}) begin
        errors++; $display("FAIL dbz_hold: vld=%0b rdy=%0b q=%h r=%h dbz=%0b, required 1 0 ff 10 1",
                           bus.out_valid, bus.in_ready, bus.q, bus.r, bus.err_dbz);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.q} !== {2'b10, 8'hFF}) begin
      errors++; $display("FAIL dbz_no_accept: rdy=%0b vld=%0b q=%h, required 1 0 ff",
                         bus.in_ready, bus.out_valid, bus.q);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    start_op(16'd1000, 8'd7);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.out_valid, bus.q, bus.r} !== {1'b1, 8'd142, 8'd6}) begin
        errors++; $display("FAIL bp_stall: vld=%0b q=%0d r=%0d, required 1 142 6",
                           bus.out_valid, bus.q, bus.r);
      end
    end
    release_result();
    @(posedge clk); #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.q} !== {2'b01, 8'd142}) begin
      errors++; $display("FAIL bp_single_accept: vld=%0b rdy=%0b q=%0d, required 0 1 142",
                         bus.out_valid, bus.in_ready, bus.q);
    end
  endtask

  task automatic test_idle_out_ready;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL idle_out_ready: rdy=%0b vld=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc;
    int cyc;
    start_op(16'd1000, 8'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'b00}) begin
      errors++; $display("FAIL mid_calc_reset: rdy=%0b vld=%0b q=%0d r=%0d dbz=%0b ovf=%0b, required 1 0 0 0 0 0",
                         bus.in_ready, bus.out_valid, bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL post_reset_idle: rdy=%0b vld=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
    start_op(16'd200, 8'd9);
    wait_valid(cyc);
    vectors++;
    if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {8'd22, 8'd2, 2'b00}) begin
      errors++; $display("FAIL post_reset_op: q=%0d r=%0d dbz=%0b ovf=%0b, required 22 2 0 0",
                         bus.q, bus.r, bus.err_dbz, bus.err_ovf);
    end
    release_result();
  endtask

  task automatic test_random;
    int          cyc;
    logic [7:0]  dv, hi, lo;
    logic [15:0] dvd, eq, er;
    for (int i = 0; i < 300; i++) begin
      dv  = 8'($urandom_range(1, 255));
      hi  = 8'($urandom_range(0, int'(dv) - 1));
      lo  = 8'($urandom_range(0, 255));
      dvd = {hi, lo};
      eq  = dvd / {8'h00, dv};
      er  = dvd % {8'h00, dv};
      start_op(dvd, dv);
      wait_valid(cyc);
      vectors++;
      if ({bus.q, bus.r, bus.err_dbz, bus.err_ovf} !== {eq[7:0], er[7:0], 2'b00}) begin
        errors++; $display("FAIL random_op: %0d/%0d gave q=%0d r=%0d dbz=%0b ovf=%0b, required %0d %0d 0 0",
                           dvd, dv, bus.q, bus.r, bus.err_dbz, bus.err_ovf, eq, er);
      end
      release_result();
    end
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_max_quotient();
    test_overflow();
    test_div_by_zero();
    test_backpressure();
    test_idle_out_ready();
    test_reset_mid_calc();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
